// File: rtl/dmem_latency.sv
// dmem_latency: byte/halfword/word data memory with a programmable wait-state
// latency behind a req/ready handshake. It reports misaligned and illegal-size
// accesses through err.
module dmem_latency #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned BW = AW + 2;   // byte-address bits that select a location
    localparam int unsigned CW = 4;        // wait counter width, covers LATENCY 0..15

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          we_q,    we_d;
    logic [2:0]    f3_q,    f3_d;
    logic [BW-1:0] addr_q,  addr_d;
    logic [31:0]   wd_q,    wd_d;
    logic [31:0]   rd_q,    rd_d;
    logic          ready_q, ready_d;
    logic          err_q,   err_d;

    logic [31:0]   mem [0:DEPTH_WORDS-1];

    logic          req_err_c;
    logic          access_c;
    logic          mem_we_c;
    logic [AW-1:0] idx_c;
    logic [31:0]   rd_word_c;
    logic [3:0]    be_c;
    logic [31:0]   st_data_c;
    logic          unused_a_hi_c;

    // Illegal size/sign code or misaligned address for the requested access
    function automatic logic access_err(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic bad_code;
        logic misalign;
        if (is_store) begin
            bad_code = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
        end else begin
            bad_code = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        misalign = ((f3[1:0] == 2'b01) && lo[0]) ||
                   ((f3[1:0] == 2'b10) && (lo != 2'b00));
        return bad_code || misalign;
    endfunction

    // Select the addressed byte/halfword lanes and extend them to 32 bits
    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Byte enables for a store of the given size at lane lo
    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate low-aligned store data across all lanes so any enabled lane sees it
    function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                               input logic [31:0] d);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Upper address bits alias and are deliberately dropped
    assign unused_a_hi_c = ^a[31:BW];

    // Datapath decode of the request and the captured access
    always_comb begin
        req_err_c = access_err(we, funct3, a[1:0]);
        access_c  = (state_q == S_WAIT) && (cnt_q == '0);
        mem_we_c  = access_c && we_q;
        idx_c     = addr_q[BW-1:2];
        rd_word_c = mem[idx_c];
        be_c      = store_be(f3_q, addr_q[1:0]);
        st_data_c = store_data(f3_q, wd_q);
    end

    // Capture the request fields when a request is accepted in IDLE
    always_comb begin
        we_d   = we_q;
        f3_d   = f3_q;
        addr_d = addr_q;
        wd_d   = wd_q;
        if ((state_q == S_IDLE) && req) begin
            we_d   = we;
            f3_d   = funct3;
            addr_d = a[BW-1:0];
            wd_d   = wd;
        end
    end

    // Next state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (req_err_c) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CW'(LATENCY);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response outputs, registered on entry to RESP
    always_comb begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        rd_d    = rd_q;
        if ((state_q == S_IDLE) && req && req_err_c) begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rd_d    = '0;
        end else if (access_c) begin
            ready_d = 1'b1;
            if (!we_q) begin
                rd_d = load_ext(rd_word_c, f3_q, addr_q[1:0]);
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // RAM lane writes; contents survive reset, and reset cancels a pending write
    always_ff @(posedge clk) begin
        if (mem_we_c && !reset) begin
            for (int k = 0; k < 4; k++) begin
                if (be_c[k]) begin
                    mem[idx_c][8*k +: 8] <= st_data_c[8*k +: 8];
                end
            end
        end
    end

    assign rd    = rd_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: doc/dmem_latency.md
Name: dmem_latency

Overview:
- Parametrised successor to the single-cycle word data memory.
- Adds RISC-V byte/halfword/word loads and stores with sign or zero extension.
- Adds a programmable wait-state latency behind a req/ready handshake, plus misalignment and illegal-size error reporting.
- Sits between the pipelined core's MEM stage and the on-chip data RAM. The core stalls on req until ready.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
- LATENCY, 2, wait cycles between acceptance and response, 0..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; returns control to idle
- req  input  1  access request; sampled only in IDLE
- we  input  1  1 = store, 0 = load; sampled with req
- funct3  input  3  RISC-V size/sign code; sampled with req
- a  input  32  byte address; sampled with req
- wd  input  32  store data, low-aligned (sb uses wd[7:0], sh uses wd[15:0]); sampled with req
- rd  output  32  load result, extended; registered
- ready  output  1  one-cycle response strobe
- err  output  1  error flag; valid only when ready=1

Behaviour:
- Reset:
  - state=IDLE, counter=0, ready=0, err=0, rd=0.
  - RAM contents are not cleared.
  - Reset in WAIT aborts the access with no RAM write and no ready.
- States are IDLE, WAIT and RESP.
- IDLE:
  - With req=1 in cycle T, capture we, funct3, a and wd.
  - If the request is erroneous, go to RESP.
  - Otherwise load counter=LATENCY and go to WAIT.
- WAIT:
  - While counter != 0, decrement it.
  - When counter == 0, perform the access at this edge and go to RESP.
- RESP:
  - ready=1 for exactly one cycle, then IDLE.
  - req is ignored in WAIT and RESP; the requester holds req until it sees ready.
  - A new request can be accepted the cycle after RESP.
- Timing:
  - Good access: ready=1 in cycle T+LATENCY+2.
  - With LATENCY=0, ready=1 in T+2.
  - Error: ready=1 in T+1.
  - Throughput is one access per LATENCY+3 cycles.
- Word index is a[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS bytes.
- Little-endian: byte lane k is word bits [8k+7:8k], lane = a[1:0].
- Loads:
  - 000 lb: sign-extends byte lane a[1:0].
  - 001 lh: sign-extends halfword a[1]; lanes 0-1 or 2-3.
  - 010 lw: whole word.
  - 100 lbu: zero-extends byte lane a[1:0].
  - 101 lhu: zero-extends halfword a[1].
- Stores:
  - 000 sb: writes only lane a[1:0].
  - 001 sh: writes only lanes of halfword a[1].
  - 010 sw: writes all four lanes.
  - Unwritten lanes keep their contents.
- Errors (err=1):
  - Halfword access with a[0]=1.
  - Word access with a[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 not in {000,001,010}.
- On an error response: no RAM write, rd=0, ready=1, err=1.
- rd:
  - Updated only on a good load's RESP entry.
  - Holds its value through stores, errors and idle.
  - On reset, rd returns to 0.
- err is 0 in every cycle where ready=0.
- The write becomes visible to a load accepted in the cycle after RESP.

Test Plan:
- LATENCY=2; sw wd=0xDEADBEEF a=0x10 req at cycle 0 -> ready=1 only in cycle 4, err=0; then lw 0x10 -> rd=0xDEADBEEF.
- After the sw above:
  - lb 0x11 -> rd=0xFFFFFFBE.
  - lbu 0x13 -> rd=0x000000DE.
  - lh 0x12 -> rd=0xFFFFDEAD.
  - lhu 0x10 -> rd=0x0000BEEF.
- sb wd=0x12345655 a=0x12, then lw 0x10 -> rd=0xDE55BEEF; then sh wd=0xA5A5 a=0x10, then lw -> rd=0xDE55A5A5.
- lw a=0x06 and sh a=0x11 -> ready in cycle T+1 with err=1 and rd=0x00000000; lw 0x04 afterwards shows prior contents unchanged.
- sw 0xCAFEF00D a=0x20, assert reset in cycle T+2 -> ready never pulses, all outputs 0; lw 0x20 returns the pre-existing value.
- DEPTH_WORDS=256: sw 0x11111111 a=0x400, then lw 0x000 -> rd=0x11111111 (alias). LATENCY=0 build: ready in T+2.
- Holding req high continuously -> exactly one ready per LATENCY+3 cycles; funct3=011 load -> err=1.
